// File: rtl/uart_rx_param_pkg.sv
// Shared types and helpers for the parametrised UART receiver.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_PUSH   = 3'd5
    } rx_state_t;

    localparam int unsigned PAR_NONE      = 0;
    localparam int unsigned PAR_EVEN      = 1;
    localparam int unsigned PAR_ODD       = 2;
    localparam int unsigned MAX_DATA_BITS = 9;

    // Expected parity bit for a (zero-extended) data word.
    function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] data,
                                         input int unsigned mode);
        return (^data) ^ (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// Receive-side bus between the UART receiver and the packet processor.
interface uart_rx_param_if #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned FIFO_DEPTH = 4
) ();
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic                 data_read;
    logic [DATA_BITS-1:0] rx_data;
    logic                 data_ready;
    logic [CW-1:0]        fifo_count;
    logic                 overrun_error;
    logic                 framing_error;
    logic                 parity_error;

    modport master (
        input  data_read,
        output rx_data, data_ready, fifo_count,
        output overrun_error, framing_error, parity_error
    );

    modport slave (
        output data_read,
        input  rx_data, data_ready, fifo_count,
        input  overrun_error, framing_error, parity_error
    );
endinterface

// File: rtl/uart_rx_param_rx_fifo.sv
// First-word-fall-through receive FIFO; simultaneous push/pop allowed even when full.
module rx_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

    // Head is forced to zero while empty so the output reads 0 out of reset.
    assign rdata = empty ? '0 : mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/uart_rx_param.sv
// Oversampled UART receiver: synchroniser, bit timer, frame FSM and error flags
// feeding a FWFT receive FIFO.
module uart_rx_param
    import uart_rx_pkg::*;
#(
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned CLKS_PER_BIT = 10,
    parameter int unsigned PARITY_MODE  = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             serial_in,
    uart_rx_param_if.master  rx_if
);
    localparam int unsigned HALF = CLKS_PER_BIT / 2;
    localparam int unsigned TW   = $clog2(CLKS_PER_BIT);
    localparam int unsigned BW   = $clog2(DATA_BITS);
    localparam int unsigned CW   = $clog2(FIFO_DEPTH) + 1;

    logic                 sync1_q, sync2_q, line_q;
    rx_state_t            state_q, state_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [BW-1:0]        cnt_q, cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 framing_q, framing_d;
    logic                 parity_q, parity_d;
    logic                 overrun_q, overrun_d;

    logic                 start_edge, tick, frame_ok, pop_ok, push_c;
    logic                 fifo_empty, fifo_full;
    logic [DATA_BITS-1:0] fifo_rdata;
    logic [CW-1:0]        fifo_count;

    assign start_edge = line_q & ~sync2_q;
    assign tick       = (timer_q == '0);
    assign frame_ok   = ~framing_q & ~parity_q;
    assign pop_ok     = rx_if.data_read & ~fifo_empty;
    assign push_c     = (state_q == ST_PUSH) & frame_ok;

    // Next-state and datapath updates.
    always_comb begin
        state_d   = state_q;
        timer_d   = tick ? TW'(CLKS_PER_BIT - 1) : timer_q - TW'(1);
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        framing_d = framing_q;
        parity_d  = parity_q;
        overrun_d = overrun_q;

        if (pop_ok) overrun_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                timer_d = TW'(HALF - 1);
                if (start_edge) begin
                    state_d   = ST_START;
                    framing_d = 1'b0;
                    parity_d  = 1'b0;
                end
            end
            ST_START: begin
                if (tick) begin
                    cnt_d   = '0;
                    state_d = sync2_q ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shift_d = {sync2_q, shift_q[DATA_BITS-1:1]};
                    cnt_d   = cnt_q + BW'(1);
                    if (cnt_q == BW'(DATA_BITS - 1)) begin
                        cnt_d   = '0;
                        state_d = (PARITY_MODE != PAR_NONE) ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    parity_d = (sync2_q != calc_parity(MAX_DATA_BITS'(shift_q), PARITY_MODE));
                    state_d  = ST_STOP;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (!sync2_q) framing_d = 1'b1;
                    cnt_d = cnt_q + BW'(1);
                    if (cnt_q == BW'(STOP_BITS - 1)) state_d = ST_PUSH;
                end
            end
            ST_PUSH: begin
                state_d = ST_IDLE;
                if (frame_ok && fifo_full && !pop_ok) overrun_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            line_q    <= 1'b1;
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            cnt_q     <= '0;
            shift_q   <= '0;
            framing_q <= 1'b0;
            parity_q  <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            sync1_q   <= serial_in;
            sync2_q   <= sync1_q;
            line_q    <= sync2_q;
            state_q   <= state_d;
            timer_q   <= timer_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            framing_q <= framing_d;
            parity_q  <= parity_d;
            overrun_q <= overrun_d;
        end
    end

    rx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .n_rst (n_rst),
        .push  (push_c),
        .pop   (rx_if.data_read),
        .wdata (shift_q),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    assign rx_if.rx_data       = fifo_rdata;
    assign rx_if.data_ready    = ~fifo_empty;
    assign rx_if.fifo_count    = fifo_count;
    assign rx_if.overrun_error = overrun_q;
    assign rx_if.framing_error = framing_q;
    assign rx_if.parity_error  = parity_q;

endmodule
